// File: rtl/object_pkg.sv
// Shared definitions for the object request bus: map cell type codes,
// request kinds, exist codes, status field layout and arbiter states.
package object_pkg;

  localparam int H_WIDTH           = 4;
  localparam int V_WIDTH           = 4;
  localparam int TYPE_WIDTH        = 4;
  localparam int EXIST_WIDTH       = 2;
  localparam int DIR_WIDTH         = 2;
  localparam int STATUS_WIDTH      = 16;
  localparam int REQ_CONTENT_WIDTH = 8;

  // status = {exist, x, y, dir, type}
  localparam int ST_TYPE_LSB  = 0;
  localparam int ST_DIR_LSB   = ST_TYPE_LSB + TYPE_WIDTH;
  localparam int ST_Y_LSB     = ST_DIR_LSB + DIR_WIDTH;
  localparam int ST_X_LSB     = ST_Y_LSB + V_WIDTH;
  localparam int ST_EXIST_LSB = ST_X_LSB + H_WIDTH;

  localparam logic [H_WIDTH-1:0] HMAX = 4'd15;
  localparam logic [V_WIDTH-1:0] VMAX = 4'd10;

  localparam logic [TYPE_WIDTH-1:0] OBJ_EMPTY    = 4'd0;
  localparam logic [TYPE_WIDTH-1:0] OBJ_DIGGER   = 4'd1;
  localparam logic [TYPE_WIDTH-1:0] OBJ_GOBLIN   = 4'd2;
  localparam logic [TYPE_WIDTH-1:0] OBJ_MONEYBAG = 4'd3;
  localparam logic [TYPE_WIDTH-1:0] OBJ_BLOCK    = 4'd15;

  localparam logic REQ_DROP      = 1'b0;
  localparam logic REQ_TRANSFORM = 1'b1;

  localparam logic [EXIST_WIDTH-1:0] MB_NONE    = 2'b00;
  localparam logic [EXIST_WIDTH-1:0] MB_STILL   = 2'b01;
  localparam logic [EXIST_WIDTH-1:0] MB_FALLING = 2'b10;
  localparam logic [EXIST_WIDTH-1:0] MB_BROKEN  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_DECIDE = 3'd2,
    ST_WR_OLD = 3'd3,
    ST_WR_NEW = 3'd4,
    ST_RESP   = 3'd5,
    ST_COOL   = 3'd6
  } arb_state_e;

endpackage

// File: rtl/object_arbiter_rr_grant.sv
// Round-robin picker: first eligible requester at or after the pointer,
// wrapping past N-1 back to 0. Purely combinational.
module rr_grant #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic          valid_o
);

  // scan from the pointer upwards, keep only the first hit
  always_comb begin
    int idx;
    idx     = 0;
    grant_o = '0;
    valid_o = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      if (!valid_o && eligible_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/object_arbiter.sv
// Object request arbiter: grants one object per transaction, checks the
// target map cell, moves the object in the map and answers ACK/NACK.
// Optional macro ARB_BOUNDS_CHECK_EN: out-of-range DROP targets are refused
// straight from READ without using the map read.
//
// state     | meaning
// IDLE      | waiting for an eligible request
// READ      | target cell address on the map bus
// DECIDE    | map data valid, choose move / refuse / transform
// WR_OLD    | clear own cell
// WR_NEW    | write own type into target cell
// RESP      | one-cycle ACK or NACK to the granted object
// COOL      | gap so the requester can drop req
module object_arbiter
  import object_pkg::*;
#(
  parameter int N_OBJ = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_OBJ-1:0]                 req,
  input  logic [N_OBJ-1:0]                 req_type,
  input  logic [N_OBJ*REQ_CONTENT_WIDTH-1:0] req_content,
  input  logic [N_OBJ*STATUS_WIDTH-1:0]    status,
  output logic [N_OBJ-1:0]                 ACK,
  output logic [N_OBJ-1:0]                 NACK,
  output logic [H_WIDTH+V_WIDTH-1:0]       map_addr,
  input  logic [TYPE_WIDTH-1:0]            map_rdata,
  output logic                             map_we,
  output logic [TYPE_WIDTH-1:0]            map_wdata,
  output logic                             busy
);

  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  arb_state_e state_q, state_d;
  logic [IW-1:0]         rr_q, idx_q, gnt_idx;
  logic                  type_q, ack_q, ack_d;
  logic [H_WIDTH-1:0]    tgt_x_q, own_x_q;
  logic [V_WIDTH-1:0]    tgt_y_q, own_y_q;
  logic [TYPE_WIDTH-1:0] own_type_q;

  logic [N_OBJ-1:0]             elig, gnt_oh;
  logic                         gnt_vld, sel_type;
  logic [REQ_CONTENT_WIDTH-1:0] sel_content;
  logic [STATUS_WIDTH-1:0]      sel_status;
  logic                         unused_sel;

  // requesters whose object no longer exists are invisible to the arbiter
  always_comb begin
    for (int i = 0; i < N_OBJ; i++)
      elig[i] = req[i] &&
                (status[i*STATUS_WIDTH+ST_EXIST_LSB +: EXIST_WIDTH] != MB_NONE);
  end

  rr_grant #(.N(N_OBJ), .IW(IW)) u_rr_grant (
    .eligible_i(elig),
    .ptr_i     (rr_q),
    .grant_o   (gnt_oh),
    .valid_o   (gnt_vld)
  );

  // one-hot grant to index plus the granted object's request fields
  always_comb begin
    gnt_idx     = '0;
    sel_type    = 1'b0;
    sel_content = '0;
    sel_status  = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (gnt_oh[i]) begin
        gnt_idx     = IW'(i);
        sel_type    = req_type[i];
        sel_content = req_content[i*REQ_CONTENT_WIDTH +: REQ_CONTENT_WIDTH];
        sel_status  = status[i*STATUS_WIDTH +: STATUS_WIDTH];
      end
    end
  end

  assign unused_sel = ^{sel_status[ST_EXIST_LSB +: EXIST_WIDTH],
                        sel_status[ST_DIR_LSB +: DIR_WIDTH]};

  // state and response flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // latch the granted request once; later req changes do not matter
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= '0;
      idx_q      <= '0;
      type_q     <= 1'b0;
      tgt_x_q    <= '0;
      tgt_y_q    <= '0;
      own_x_q    <= '0;
      own_y_q    <= '0;
      own_type_q <= '0;
    end else begin
      if (state_q == ST_IDLE && gnt_vld) begin
        idx_q      <= gnt_idx;
        type_q     <= sel_type;
        tgt_x_q    <= sel_content[REQ_CONTENT_WIDTH-1 -: H_WIDTH];
        tgt_y_q    <= sel_content[V_WIDTH-1:0];
        own_x_q    <= sel_status[ST_X_LSB +: H_WIDTH];
        own_y_q    <= sel_status[ST_Y_LSB +: V_WIDTH];
        own_type_q <= sel_status[ST_TYPE_LSB +: TYPE_WIDTH];
      end
      if (state_q == ST_RESP)
        rr_q <= (idx_q == IW'(N_OBJ - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // next state and bus outputs
  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    ACK       = '0;
    NACK      = '0;
    map_we    = 1'b0;
    map_addr  = '0;
    map_wdata = '0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (gnt_vld) state_d = ST_READ;
      end
      ST_READ: begin
        map_addr = {tgt_y_q, tgt_x_q};
        state_d  = ST_DECIDE;
`ifdef ARB_BOUNDS_CHECK_EN
        if (type_q == REQ_DROP && (tgt_x_q > HMAX || tgt_y_q > VMAX)) begin
          ack_d   = 1'b0;
          state_d = ST_RESP;
        end
`endif
      end
      ST_DECIDE: begin
        map_addr = {tgt_y_q, tgt_x_q};
        if (type_q == REQ_TRANSFORM) begin
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else if (map_rdata == OBJ_EMPTY) begin
          ack_d   = 1'b1;
          state_d = ST_WR_OLD;
        end else begin
          ack_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_WR_OLD: begin
        map_we    = 1'b1;
        map_addr  = {own_y_q, own_x_q};
        map_wdata = OBJ_EMPTY;
        state_d   = ST_WR_NEW;
      end
      ST_WR_NEW: begin
        map_we    = 1'b1;
        map_addr  = {tgt_y_q, tgt_x_q};
        map_wdata = own_type_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        ACK[idx_q]  = ack_q;
        NACK[idx_q] = ~ack_q;
        state_d     = ST_COOL;
      end
      ST_COOL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // a reset in flight must not let a write or response escape on this edge
    if (rst) begin
      map_we = 1'b0;
      ACK    = '0;
      NACK   = '0;
    end
  end

endmodule
